seq_addsub: RTL and testbench

SEQ_ADDSUB -- requirements
Module: seq_addsub

---
 rtl/seq_addsub.sv | 162 ++++++++++++++++
 tb/tb_seq_addsub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Chunk-serial add/subtract unit: ADD, SUB, ADC and SBB over WIDTH bits,
// processing CHUNK bits per clock with a lookahead adder per chunk.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (ready only when idle)
//   a, b, op, cin     operands, op (00 ADD, 01 SUB, 10 ADC, 11 SBB), carry/borrow in
//   out_valid/out_ready result handshake (valid only when done)
//   z                 result
//   carry, parity, overflow, zero, sign  result flags
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             parity,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic             cy_r;
    logic [IW-1:0]    idx;
    logic             last;

    int               lo;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             term;
    logic             pchain;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (idx == IW'(N - 1));

    always_comb begin
        lo = CHUNK * int'(idx);
        ca = a_r[lo +: CHUNK];
        cb = b_r[lo +: CHUNK];
    end

    // Each carry is a flat sum of products: g[i] | p[i]g[i-1] | ... | p[i..0]c0,
    // so no carry depends on a previously computed carry.
    always_comb begin
        g      = ca & cb;
        p      = ca ^ cb;
        c      = '0;
        c[0]   = cy_r;
        term   = 1'b0;
        pchain = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            term   = g[i];
            pchain = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[i+1] = term | (pchain & cy_r);
        end
        sum = p ^ c[CHUNK-1:0];
    end

    // Full result as it will look once this chunk is written back.
    always_comb begin
        res = z;
        res[lo +: CHUNK] = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            cy_r     <= 1'b0;
            idx      <= '0;
            z        <= '0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            sign     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= op[0] ? ~b : b;
                        sub_r <= op[0];
                        // ADD:0  SUB:1  ADC:cin  SBB:~cin
                        cy_r  <= op[1] ? (cin ^ op[0]) : op[0];
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    z    <= res;
                    cy_r <= c[CHUNK];
                    if (!last) begin
                        idx <= idx + 1'b1;
                    end else begin
                        carry    <= c[CHUNK] ^ sub_r;
                        sign     <= res[WIDTH-1];
                        zero     <= (res == '0);
                        parity   <= ~^res;
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (res[WIDTH-1] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Randomized self-checking bench for seq_addsub: a 16/4 instance and an
// 8/8 instance, compared against an arithmetic reference model.
module tb_seq_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        iv16 = 1'b0;
    logic        iv8 = 1'b0;
    logic        sel8 = 1'b0;

    logic        ir16, ov16, cy16, pa16, of16, ze16, sg16;
    logic [15:0] z16;
    logic        ir8, ov8, cy8, pa8, of8, ze8, sg8;
    logic [7:0]  z8;

    logic        cur_ir, cur_ov;
    logic [15:0] cur_z;
    logic [4:0]  cur_f;

    int errors = 0;
    int checks = 0;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a), .b(b), .op(op), .cin(cin),
        .out_valid(ov16), .out_ready(out_ready), .z(z16),
        .carry(cy16), .parity(pa16), .overflow(of16), .zero(ze16), .sign(sg16)
    );

    seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .op(op), .cin(cin),
        .out_valid(ov8), .out_ready(out_ready), .z(z8),
        .carry(cy8), .parity(pa8), .overflow(of8), .zero(ze8), .sign(sg8)
    );

    always_comb begin
        if (sel8) begin
            cur_ir = ir8;
            cur_ov = ov8;
            cur_z  = {8'h00, z8};
            cur_f  = {cy8, pa8, of8, ze8, sg8};
        end else begin
            cur_ir = ir16;
            cur_ov = ov16;
            cur_z  = z16;
            cur_f  = {cy16, pa16, of16, ze16, sg16};
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flags packed as {carry, parity, overflow, zero, sign}.
    function automatic void model(input int w, input logic [15:0] ai,
                                  input logic [15:0] bi, input logic [1:0] o,
                                  input logic ci, output logic [15:0] ez,
                                  output logic [4:0] ef);
        longint ua, ub, m, sa, sb, ur, sr, cl;
        logic   cf, of, zf, pf, sf;
        ua = longint'(ai);
        ub = longint'(bi);
        m  = longint'(1) << w;
        cl = longint'(ci);
        sa = ai[w-1] ? ua - m : ua;
        sb = bi[w-1] ? ub - m : ub;
        case (o)
            2'b00: begin ur = ua + ub;      sr = sa + sb;      cf = (ur >= m); end
            2'b10: begin ur = ua + ub + cl; sr = sa + sb + cl; cf = (ur >= m); end
            2'b01: begin ur = ua - ub;      sr = sa - sb;      cf = (ua < ub); end
            default: begin
                ur = ua - ub - cl;
                sr = sa - sb - cl;
                cf = (ua < ub + cl);
            end
        endcase
        ez = 16'(ur & (m - 1));
        of = (sr > (m / 2) - 1) || (sr < -(m / 2));
        zf = (ez == 16'd0);
        sf = ez[w-1];
        pf = ~^ez;
        ef = {cf, pf, of, zf, sf};
    endfunction

    task automatic scramble();
        a   = 16'($urandom);
        b   = 16'($urandom);
        op  = 2'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic do_op(input logic s8, input logic [15:0] ai,
                         input logic [15:0] bi, input logic [1:0] o,
                         input logic ci, input int hold);
        logic [15:0] ez;
        logic [4:0]  ef;
        int          w, n, cyc;
        w = s8 ? 8 : 16;
        n = s8 ? 1 : 4;
        if (s8) begin
            ai[15:8] = 8'h00;
            bi[15:8] = 8'h00;
        end
        model(w, ai, bi, o, ci, ez, ef);
        sel8 = s8;
        a = ai; b = bi; op = o; cin = ci;
        iv16 = !s8;
        iv8  = s8;
        check("in_ready_idle", 32'(cur_ir), 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        iv8  = 1'b0;
        scramble();
        check("in_ready_busy", 32'(cur_ir), 32'd0);
        cyc = 0;
        while (!cur_ov && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(n));
        check("z", 32'(cur_z), 32'(ez));
        check("flags", 32'(cur_f), 32'(ef));
        repeat (hold) begin
            scramble();
            iv16 = 1'b1;
            iv8  = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(cur_ov), 32'd1);
            check("hold_ready", 32'(cur_ir), 32'd0);
            check("hold_z", 32'(cur_z), 32'(ez));
            check("hold_flags", 32'(cur_f), 32'(ef));
        end
        iv16 = 1'b0;
        iv8  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ret_ready", 32'(cur_ir), 32'd1);
        check("ret_valid", 32'(cur_ov), 32'd0);
        check("keep_z", 32'(cur_z), 32'(ez));
        check("keep_flags", 32'(cur_f), 32'(ef));
        @(posedge clk); #1;
        check("stay_idle", 32'(cur_ir), 32'd1);
    endtask

    task automatic check_reset(input logic s8);
        sel8 = s8;
        check("rst_ready", 32'(cur_ir), 32'd1);
        check("rst_valid", 32'(cur_ov), 32'd0);
        check("rst_z", 32'(cur_z), 32'd0);
        check("rst_flags", 32'(cur_f), 32'd0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check_reset(1'b0);
        check_reset(1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 16'h7FFF, 16'h0001, 2'b00, 1'b0, 0);
        do_op(1'b0, 16'hFFFF, 16'h0001, 2'b00, 1'b1, 0);
        do_op(1'b0, 16'h0003, 16'h0005, 2'b01, 1'b0, 0);
        do_op(1'b0, 16'h8000, 16'h0001, 2'b01, 1'b1, 0);
        do_op(1'b0, 16'h1234, 16'h4321, 2'b10, 1'b1, 3);

        // Abort in the second busy cycle.
        sel8 = 1'b0;
        a = 16'h5555; b = 16'h1111; op = 2'b00; cin = 1'b0;
        iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset(1'b0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (cur_ov) seen = 1;
        end
        check("no_pulse", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            do_op(1'b0, 16'($urandom), 16'($urandom), 2'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)));
        end

        do_op(1'b1, 16'h00FF, 16'h0000, 2'b10, 1'b1, 0);
        do_op(1'b1, 16'h0000, 16'h0000, 2'b11, 1'b1, 1);
        for (int i = 0; i < 12; i++) begin
            do_op(1'b1, 16'($urandom), 16'($urandom), 2'($urandom),
                  1'($urandom), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
